// File: rtl/uart_fifo_wb.sv
// uart_fifo_wb: Wishbone-slave UART with programmable divisor and TX/RX FIFOs.
// Ports:
//   wb_clk_i, wb_rst_i         clock, synchronous active-high reset
//   wb_adr_i/dat_i/we/sel/stb/cyc  Wishbone slave request
//   wb_dat_o, wb_ack_o         registered read data and single-cycle acknowledge
//   int_o                      level interrupt, active-high
//   stx_pad_o, srx_pad_i       serial out (idle high), asynchronous serial in
// Also contains uart_fifo_wb_fifo, the synchronous FIFO used for TX and RX.

module uart_fifo_wb_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic                   pop,
  input  logic [WIDTH-1:0]       wdata,
  output logic [WIDTH-1:0]       rdata_c,
  output logic [$clog2(DEPTH):0] count,
  output logic                   empty_c,
  output logic                   full_c
);
  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             push_ok_c, pop_ok_c;

  assign empty_c = (cnt_q == '0);
  assign full_c  = (cnt_q == CW'(DEPTH));
  assign rdata_c = mem_q[rd_ptr_q];
  assign count   = cnt_q;

  // A pop frees a slot in the same cycle, so push on full succeeds with pop.
  assign push_ok_c = push & (~full_c | pop);
  assign pop_ok_c  = pop & ~empty_c;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q + CW'(push_ok_c) - CW'(pop_ok_c);
    if (push_ok_c) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop_ok_c)  rd_ptr_d = rd_ptr_q + AW'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  // Storage needs no reset; pointers define validity.
  always_ff @(posedge clk) begin
    if (push_ok_c) mem_q[wr_ptr_q] <= wdata;
  end
endmodule

module uart_fifo_wb #(
  parameter int unsigned DATA_BITS   = 8,
  parameter int unsigned FIFO_DEPTH  = 16,
  parameter logic [15:0] DEFAULT_DIV = 16'd433
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  input  logic [3:0]  wb_adr_i,
  input  logic [31:0] wb_dat_i,
  output logic [31:0] wb_dat_o,
  input  logic        wb_we_i,
  input  logic [3:0]  wb_sel_i,
  input  logic        wb_stb_i,
  input  logic        wb_cyc_i,
  output logic        wb_ack_o,
  output logic        int_o,
  output logic        stx_pad_o,
  input  logic        srx_pad_i
);
  localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;
  localparam int unsigned BW = $clog2(DATA_BITS);

  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} uart_state_e;

  // Bus / register state
  logic        ack_q, ack_d;
  logic [31:0] dat_q, dat_d;
  logic        int_q, int_d;
  logic [15:0] div_q, div_d;
  logic        tx_en_q, tx_en_d, rx_en_q, rx_en_d, lb_q, lb_d;
  logic        irq_rx_en_q, irq_rx_en_d, irq_tx_en_q, irq_tx_en_d;
  logic        irq_err_en_q, irq_err_en_d;
  logic [8:0]  thr_q, thr_d;
  logic        rx_ovr_q, rx_ovr_d, frm_err_q, frm_err_d, tx_ovf_q, tx_ovf_d;

  // TX state
  uart_state_e          tx_state_q, tx_state_d;
  logic [15:0]          tx_cnt_q, tx_cnt_d, tx_bdiv_q, tx_bdiv_d;
  logic [BW-1:0]        tx_bit_q, tx_bit_d;
  logic [DATA_BITS-1:0] tx_shift_q, tx_shift_d;
  logic                 stx_q, stx_d;

  // RX state
  logic                 rx_s1_q, rx_s1_d, rx_s2_q, rx_s2_d, rx_prev_q, rx_prev_d;
  uart_state_e          rx_state_q, rx_state_d;
  logic [15:0]          rx_cnt_q, rx_cnt_d, rx_bdiv_q, rx_bdiv_d;
  logic [BW-1:0]        rx_bit_q, rx_bit_d;
  logic [DATA_BITS-1:0] rx_shift_q, rx_shift_d;
  logic                 rx_vld1_q, rx_vld1_d, rx_vld2_q, rx_vld2_d;

  // Combinational helpers
  logic                 req_c, rd_c, wr_c;
  logic [1:0]           reg_sel_c;
  logic                 tx_push_c, tx_pop_c, rx_pop_c;
  logic [DATA_BITS-1:0] tx_rdata_c, rx_rdata_c;
  logic [CW-1:0]        tx_count_c, rx_count_c;
  logic [8:0]           rx_cnt9_c;
  logic                 tx_empty_c, tx_full_c, rx_empty_c, rx_full_c;
  logic                 tx_busy_c, frm_evt_c;
  logic [15:0]          div_eff_c, rx_half_c;
  logic [31:0]          status_c, ctrl_c;
  logic                 rx_fall_c, tx_bit_end_c, rx_bit_end_c;
  logic                 unused_c;

  assign wb_ack_o  = ack_q;
  assign wb_dat_o  = dat_q;
  assign int_o     = int_q;
  assign stx_pad_o = stx_q;

  // A new request is only taken while no ack is outstanding.
  assign req_c     = wb_stb_i & wb_cyc_i & ~ack_q;
  assign rd_c      = req_c & ~wb_we_i;
  assign wr_c      = req_c & wb_we_i;
  assign reg_sel_c = wb_adr_i[3:2];

  assign tx_push_c = wr_c & (reg_sel_c == 2'd0) & wb_sel_i[0];
  assign rx_pop_c  = rd_c & (reg_sel_c == 2'd0);

  assign div_eff_c = (div_q < 16'd3) ? 16'd3 : div_q;
  assign tx_busy_c = (tx_state_q != S_IDLE);
  assign rx_cnt9_c = 9'(rx_count_c);

  assign status_c = {15'd0, rx_cnt9_c, tx_ovf_q, frm_err_q, rx_ovr_q, tx_busy_c,
                     tx_full_c, tx_empty_c, rx_full_c, rx_empty_c};
  assign ctrl_c   = {10'd0, irq_err_en_q, irq_tx_en_q, irq_rx_en_q, lb_q,
                     rx_en_q, tx_en_q, div_q};

  assign unused_c = ^{wb_adr_i[1:0], wb_dat_i[31:25], tx_count_c};

  uart_fifo_wb_fifo #(.WIDTH(DATA_BITS), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
    .clk     (wb_clk_i),
    .rst     (wb_rst_i),
    .push    (tx_push_c),
    .pop     (tx_pop_c),
    .wdata   (wb_dat_i[DATA_BITS-1:0]),
    .rdata_c (tx_rdata_c),
    .count   (tx_count_c),
    .empty_c (tx_empty_c),
    .full_c  (tx_full_c)
  );

  uart_fifo_wb_fifo #(.WIDTH(DATA_BITS), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
    .clk     (wb_clk_i),
    .rst     (wb_rst_i),
    .push    (rx_vld2_q),
    .pop     (rx_pop_c),
    .wdata   (rx_shift_q),
    .rdata_c (rx_rdata_c),
    .count   (rx_count_c),
    .empty_c (rx_empty_c),
    .full_c  (rx_full_c)
  );

  // Register file, Wishbone response, sticky status and interrupt.
  always_comb begin
    ack_d        = req_c;
    dat_d        = '0;
    div_d        = div_q;
    tx_en_d      = tx_en_q;
    rx_en_d      = rx_en_q;
    lb_d         = lb_q;
    irq_rx_en_d  = irq_rx_en_q;
    irq_tx_en_d  = irq_tx_en_q;
    irq_err_en_d = irq_err_en_q;
    thr_d        = thr_q;
    rx_ovr_d     = rx_ovr_q;
    frm_err_d    = frm_err_q;
    tx_ovf_d     = tx_ovf_q;

    // Read data captures state before this access's side effect.
    if (rd_c) begin
      case (reg_sel_c)
        2'd0:    dat_d = rx_empty_c ? 32'd0 : 32'(rx_rdata_c);
        2'd1:    dat_d = status_c;
        2'd2:    dat_d = ctrl_c;
        default: dat_d = {7'd0, thr_q, 8'd0, status_c[7:0]};
      endcase
    end

    if (wr_c) begin
      case (reg_sel_c)
        2'd2: begin
          if (wb_sel_i[0]) div_d[7:0]  = wb_dat_i[7:0];
          if (wb_sel_i[1]) div_d[15:8] = wb_dat_i[15:8];
          if (wb_sel_i[2]) begin
            tx_en_d      = wb_dat_i[16];
            rx_en_d      = wb_dat_i[17];
            lb_d         = wb_dat_i[18];
            irq_rx_en_d  = wb_dat_i[19];
            irq_tx_en_d  = wb_dat_i[20];
            irq_err_en_d = wb_dat_i[21];
          end
        end
        2'd3: begin
          if (wb_sel_i[0]) begin
            if (wb_dat_i[5]) rx_ovr_d  = 1'b0;
            if (wb_dat_i[6]) frm_err_d = 1'b0;
            if (wb_dat_i[7]) tx_ovf_d  = 1'b0;
          end
          if (wb_sel_i[2]) thr_d[7:0] = wb_dat_i[23:16];
          if (wb_sel_i[3]) thr_d[8]   = wb_dat_i[24];
        end
        default: ;
      endcase
    end

    // New error events win over a same-cycle W1C.
    if (tx_push_c & tx_full_c & ~tx_pop_c) tx_ovf_d  = 1'b1;
    if (rx_vld2_q & rx_full_c & ~rx_pop_c) rx_ovr_d  = 1'b1;
    if (frm_evt_c)                         frm_err_d = 1'b1;

    int_d = (irq_rx_en_q & (rx_cnt9_c >= thr_q) & (thr_q != 9'd0)) |
            (irq_tx_en_q & tx_empty_c) |
            (irq_err_en_q & (rx_ovr_q | frm_err_q | tx_ovf_q));
  end

  // Transmitter. Divisor is latched per bit so CTRL writes apply at bit boundaries.
  assign tx_bit_end_c = (tx_cnt_q == tx_bdiv_q);

  always_comb begin
    tx_state_d = tx_state_q;
    tx_cnt_d   = tx_cnt_q;
    tx_bdiv_d  = tx_bdiv_q;
    tx_bit_d   = tx_bit_q;
    tx_shift_d = tx_shift_q;
    tx_pop_c   = 1'b0;

    case (tx_state_q)
      S_IDLE: begin
        if (tx_en_q & ~tx_empty_c) begin
          tx_pop_c   = 1'b1;
          tx_state_d = S_START;
          tx_cnt_d   = '0;
          tx_bdiv_d  = div_eff_c;
          tx_shift_d = tx_rdata_c;
        end
      end
      S_START: begin
        if (tx_bit_end_c) begin
          tx_state_d = S_DATA;
          tx_cnt_d   = '0;
          tx_bit_d   = '0;
          tx_bdiv_d  = div_eff_c;
        end else begin
          tx_cnt_d = tx_cnt_q + 16'd1;
        end
      end
      S_DATA: begin
        if (tx_bit_end_c) begin
          tx_cnt_d  = '0;
          tx_bdiv_d = div_eff_c;
          if (tx_bit_q == BW'(DATA_BITS - 1)) tx_state_d = S_STOP;
          else                                tx_bit_d   = tx_bit_q + BW'(1);
        end else begin
          tx_cnt_d = tx_cnt_q + 16'd1;
        end
      end
      default: begin
        if (tx_bit_end_c) begin
          // Chain straight into the next frame to avoid an idle gap.
          if (tx_en_q & ~tx_empty_c) begin
            tx_pop_c   = 1'b1;
            tx_state_d = S_START;
            tx_cnt_d   = '0;
            tx_bdiv_d  = div_eff_c;
            tx_shift_d = tx_rdata_c;
          end else begin
            tx_state_d = S_IDLE;
          end
        end else begin
          tx_cnt_d = tx_cnt_q + 16'd1;
        end
      end
    endcase

    // Pin follows the state one cycle later.
    case (tx_state_q)
      S_START: stx_d = 1'b0;
      S_DATA:  stx_d = tx_shift_q[tx_bit_q];
      default: stx_d = 1'b1;
    endcase
  end

  // Receiver: synchroniser, falling-edge detect, mid-bit sampling.
  assign rx_fall_c    = rx_prev_q & ~rx_s2_q;
  assign rx_bit_end_c = (rx_cnt_q == rx_bdiv_q);
  assign rx_half_c    = 16'(({1'b0, rx_bdiv_q} + 17'd1) >> 1);

  always_comb begin
    rx_s1_d    = lb_q ? stx_q : srx_pad_i;
    rx_s2_d    = rx_s1_q;
    rx_prev_d  = rx_s2_q;
    rx_state_d = rx_state_q;
    rx_cnt_d   = rx_cnt_q;
    rx_bdiv_d  = rx_bdiv_q;
    rx_bit_d   = rx_bit_q;
    rx_shift_d = rx_shift_q;
    rx_vld1_d  = 1'b0;
    rx_vld2_d  = rx_vld1_q;
    frm_evt_c  = 1'b0;

    case (rx_state_q)
      S_IDLE: begin
        if (rx_en_q & rx_fall_c) begin
          rx_state_d = S_START;
          rx_cnt_d   = 16'd1;
          rx_bdiv_d  = div_eff_c;
        end
      end
      S_START: begin
        if (rx_cnt_q == rx_half_c) begin
          if (rx_s2_q) begin
            rx_state_d = S_IDLE;
          end else begin
            rx_state_d = S_DATA;
            rx_cnt_d   = '0;
            rx_bit_d   = '0;
            rx_bdiv_d  = div_eff_c;
          end
        end else begin
          rx_cnt_d = rx_cnt_q + 16'd1;
        end
      end
      S_DATA: begin
        if (rx_bit_end_c) begin
          rx_shift_d = {rx_s2_q, rx_shift_q[DATA_BITS-1:1]};
          rx_cnt_d   = '0;
          rx_bdiv_d  = div_eff_c;
          if (rx_bit_q == BW'(DATA_BITS - 1)) rx_state_d = S_STOP;
          else                                rx_bit_d   = rx_bit_q + BW'(1);
        end else begin
          rx_cnt_d = rx_cnt_q + 16'd1;
        end
      end
      default: begin
        if (rx_bit_end_c) begin
          rx_state_d = S_IDLE;
          if (rx_s2_q) rx_vld1_d = 1'b1;
          else         frm_evt_c = 1'b1;
        end else begin
          rx_cnt_d = rx_cnt_q + 16'd1;
        end
      end
    endcase
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      ack_q        <= 1'b0;
      dat_q        <= '0;
      int_q        <= 1'b0;
      div_q        <= DEFAULT_DIV;
      tx_en_q      <= 1'b0;
      rx_en_q      <= 1'b0;
      lb_q         <= 1'b0;
      irq_rx_en_q  <= 1'b0;
      irq_tx_en_q  <= 1'b0;
      irq_err_en_q <= 1'b0;
      thr_q        <= 9'd1;
      rx_ovr_q     <= 1'b0;
      frm_err_q    <= 1'b0;
      tx_ovf_q     <= 1'b0;
      tx_state_q   <= S_IDLE;
      tx_cnt_q     <= '0;
      tx_bdiv_q    <= 16'd3;
      tx_bit_q     <= '0;
      tx_shift_q   <= '0;
      stx_q        <= 1'b1;
      rx_s1_q      <= 1'b1;
      rx_s2_q      <= 1'b1;
      rx_prev_q    <= 1'b1;
      rx_state_q   <= S_IDLE;
      rx_cnt_q     <= '0;
      rx_bdiv_q    <= 16'd3;
      rx_bit_q     <= '0;
      rx_shift_q   <= '0;
      rx_vld1_q    <= 1'b0;
      rx_vld2_q    <= 1'b0;
    end else begin
      ack_q        <= ack_d;
      dat_q        <= dat_d;
      int_q        <= int_d;
      div_q        <= div_d;
      tx_en_q      <= tx_en_d;
      rx_en_q      <= rx_en_d;
      lb_q         <= lb_d;
      irq_rx_en_q  <= irq_rx_en_d;
      irq_tx_en_q  <= irq_tx_en_d;
      irq_err_en_q <= irq_err_en_d;
      thr_q        <= thr_d;
      rx_ovr_q     <= rx_ovr_d;
      frm_err_q    <= frm_err_d;
      tx_ovf_q     <= tx_ovf_d;
      tx_state_q   <= tx_state_d;
      tx_cnt_q     <= tx_cnt_d;
      tx_bdiv_q    <= tx_bdiv_d;
      tx_bit_q     <= tx_bit_d;
      tx_shift_q   <= tx_shift_d;
      stx_q        <= stx_d;
      rx_s1_q      <= rx_s1_d;
      rx_s2_q      <= rx_s2_d;
      rx_prev_q    <= rx_prev_d;
      rx_state_q   <= rx_state_d;
      rx_cnt_q     <= rx_cnt_d;
      rx_bdiv_q    <= rx_bdiv_d;
      rx_bit_q     <= rx_bit_d;
      rx_shift_q   <= rx_shift_d;
      rx_vld1_q    <= rx_vld1_d;
      rx_vld2_q    <= rx_vld2_d;
    end
  end
endmodule
